// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: request handshake, operands and response handshake.
// ALU_OP_CHECK_EN adds the rsp_err response flag.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_opA;
  logic [2*WIDTH-1:0] req_opB;
  logic [11:0]        req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zf;
`ifdef ALU_OP_CHECK_EN
  logic               rsp_err;

  modport slave (
    input  req_valid, req_opA, req_opB, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zf, rsp_err
  );

  modport master (
    output req_valid, req_opA, req_opB, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zf, rsp_err
  );
`else
  modport slave (
    input  req_valid, req_opA, req_opB, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zf
  );

  modport master (
    output req_valid, req_opA, req_opB, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zf
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one single-cycle ALU between two requesters with a registered response.
// Optional ALU_OP_CHECK_EN: illegal alu_op codes bypass the ALU and answer with rsp_err=1.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zf,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for req_valid; grants combinationally and latches operands
  // EXEC  | ALU driven from latches; result captured at the edge
  // RESP  | rsp_valid[owner] held until rsp_ready[owner]
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             owner;
  logic             prio;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             zf_q;

  logic             any_valid;
  logic             gnt;
  logic [WIDTH-1:0] gnt_opa;
  logic [WIDTH-1:0] gnt_opb;
  logic [5:0]       gnt_op;

  always_comb begin
    any_valid = |bus.req_valid;
    gnt       = (&bus.req_valid) ? prio : bus.req_valid[1];
    gnt_opa   = gnt ? bus.req_opA[2*WIDTH-1:WIDTH] : bus.req_opA[WIDTH-1:0];
    gnt_opb   = gnt ? bus.req_opB[2*WIDTH-1:WIDTH] : bus.req_opB[WIDTH-1:0];
    gnt_op    = gnt ? bus.req_op[11:6] : bus.req_op[5:0];
  end

`ifdef ALU_OP_CHECK_EN
  logic err_q;
  logic gnt_legal;

  always_comb begin
    case (gnt_op)
      6'h20, 6'h22, 6'h2A, 6'h00, 6'h02: gnt_legal = 1'b1;
      default:                           gnt_legal = 1'b0;
    endcase
  end

  assign bus.rsp_err = err_q;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= PRIO_INIT;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            opa_q <= gnt_opa;
            opb_q <= gnt_opb;
            op_q  <= gnt_op;
            owner <= gnt;
            prio  <= ~gnt;
`ifdef ALU_OP_CHECK_EN
            if (gnt_legal) begin
              err_q <= 1'b0;
              state <= EXEC;
            end else begin
              // Illegal op never reaches the ALU; answer straight away.
              result_q <= '0;
              zf_q     <= 1'b0;
              err_q    <= 1'b1;
              state    <= RESP;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zf_q     <= alu_zf;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE && any_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zf     = zf_q;

  // ALU sees only latched values, never the live request bus.
  assign alu_opA = opa_q;
  assign alu_opB = opb_q;
  assign alu_op  = op_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU beside it.
// Define ALU_OP_CHECK_EN to also exercise the illegal-op path.
module tb_alu_arbiter;

  logic        clk;
  logic        nrst;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [5:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zf;
  logic        busy;

  int n_checks;
  int n_fail;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32), .PRIO_INIT(1'b0)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus.slave),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zf     (alu_zf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      6'h22:   alu_result = alu_opA - alu_opB;
      6'h2A:   alu_result = ($signed(alu_opA) < $signed(alu_opB)) ? 32'd1 : 32'd0;
      6'h00:   alu_result = alu_opA << alu_opB[4:0];
      6'h02:   alu_result = alu_opA >> alu_opB[4:0];
      default: alu_result = alu_opA + alu_opB;
    endcase
    alu_zf = (alu_result == 32'd0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst          = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_opA   = '0;
    bus.req_opB   = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_zf !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b want 0/0", bus.rsp_result, bus.rsp_zf); end
    n_checks++; if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_op !== 6'h00) begin n_fail++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_opA, alu_opB, alu_op); end
`ifdef ALU_OP_CHECK_EN
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
`endif
    nrst = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_release: got busy %b rsp_valid %b want 0 00", busy, bus.rsp_valid); end
  endtask

  task automatic test_single();
    bus.req_valid       = 2'b01;
    bus.req_opA[31:0]   = 32'd5;
    bus.req_opB[31:0]   = 32'd7;
    bus.req_op[5:0]     = 6'h20;
    bus.rsp_ready       = 2'b01;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
    n_checks++; if (alu_opA !== 32'd0) begin n_fail++; $display("FAIL single_no_comb_path: got %h want 0", alu_opA); end
    step();
    bus.req_valid = 2'b00;
    #1;
    n_checks++; if (bus.req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL single_exec: got ready %b busy %b want 00 1", bus.req_ready, busy); end
    n_checks++; if (alu_opA !== 32'd5 || alu_opB !== 32'd7 || alu_op !== 6'h20) begin n_fail++; $display("FAIL single_alu_in: got %h %h %h want 5 7 20", alu_opA, alu_opB, alu_op); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_early_rsp: got %b want 00", bus.rsp_valid); end
    step();
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid); end
    n_checks++; if (bus.rsp_result !== 32'd12 || bus.rsp_zf !== 1'b0) begin n_fail++; $display("FAIL single_result: got %h/%b want 0000000c/0", bus.rsp_result, bus.rsp_zf); end
    step();
    bus.req_opA[31:0] = 32'd99;
    #1;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy %b rsp_valid %b want 0 00", busy, bus.rsp_valid); end
    n_checks++; if (alu_opA !== 32'd5) begin n_fail++; $display("FAIL single_alu_hold: got %h want 5", alu_opA); end
  endtask

  task automatic test_fairness();
    logic       exp_g;
    logic [1:0] exp_oh;
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    bus.req_valid      = 2'b11;
    bus.req_opA[31:0]  = 32'd9;
    bus.req_opB[31:0]  = 32'd9;
    bus.req_op[5:0]    = 6'h22;
    bus.req_opA[63:32] = 32'hFFFF_FFFF;
    bus.req_opB[63:32] = 32'd1;
    bus.req_op[11:6]   = 6'h2A;
    bus.rsp_ready      = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g  = (i % 2 == 1);
      exp_oh = exp_g ? 2'b10 : 2'b01;
      #1;
      n_checks++; if (bus.req_ready !== exp_oh) begin n_fail++; $display("FAIL fair_grant%0d: got %b want %b", i, bus.req_ready, exp_oh); end
      step();
      n_checks++; if (bus.req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL fair_exec%0d: got ready %b busy %b want 00 1", i, bus.req_ready, busy); end
      step();
      n_checks++; if (bus.rsp_valid !== exp_oh) begin n_fail++; $display("FAIL fair_rsp%0d: got %b want %b", i, bus.rsp_valid, exp_oh); end
      n_checks++;
      if (bus.rsp_result !== (exp_g ? 32'd1 : 32'd0) || bus.rsp_zf !== ~exp_g) begin
        n_fail++; $display("FAIL fair_result%0d: got %h/%b want %h/%b", i, bus.rsp_result, bus.rsp_zf, exp_g ? 32'd1 : 32'd0, ~exp_g);
      end
      step();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    bus.req_valid     = 2'b01;
    bus.req_opA[31:0] = 32'h10;
    bus.req_opB[31:0] = 32'h20;
    bus.req_op[5:0]   = 6'h20;
    bus.rsp_ready     = 2'b00;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h30 || bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid %b result %h ready %b busy %b want 01 30 00 1", k, bus.rsp_valid, bus.rsp_result, bus.req_ready, busy);
      end
      bus.rsp_ready = (k == 2) ? 2'b10 : 2'b00;
      step();
    end
    n_checks++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL bp_nonowner_ready: got %b want 01", bus.rsp_valid); end
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b00;
    step();
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_release: got busy %b valid %b want 0 00", busy, bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid      = 2'b10;
    bus.req_opA[63:32] = 32'd4;
    bus.req_opB[63:32] = 32'd1;
    bus.req_op[11:6]   = 6'h00;
    bus.rsp_ready      = 2'b11;
    #1;
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL mid_grant: got %b want 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    n_checks++; if (alu_opA !== 32'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_exec: got opA %h busy %b want 4 1", alu_opA, busy); end
    nrst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_reset_state: got busy %b valid %b want 0 00", busy, bus.rsp_valid); end
    n_checks++; if (alu_opA !== 32'd0 || alu_opB !== 32'd0 || alu_op !== 6'h00) begin n_fail++; $display("FAIL mid_reset_alu: got %h %h %h want 0 0 0", alu_opA, alu_opB, alu_op); end
    n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_zf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rsp: got %h/%b want 0/0", bus.rsp_result, bus.rsp_zf); end
    nrst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp%0d: got valid %b busy %b want 00 0", k, bus.rsp_valid, busy); end
    end
    // Grant req0 so prio moves to 1, then reset must bring it back to PRIO_INIT.
    bus.req_valid     = 2'b01;
    bus.req_opA[31:0] = 32'd2;
    bus.req_opB[31:0] = 32'd2;
    bus.req_op[5:0]   = 6'h20;
    step();
    bus.req_valid = 2'b00;
    #1;
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_prio_init: got %b want 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_ops();
    logic        t_req [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_a   [4]  = '{32'd4, 32'h80, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] t_b   [4]  = '{32'd1, 32'd3, 32'd5, 32'd1};
    logic [5:0]  t_op  [4]  = '{6'h00, 6'h02, 6'h22, 6'h20};
    logic [31:0] t_res [4]  = '{32'd8, 32'h10, 32'hFFFF_FFFE, 32'd0};
    logic [1:0]  exp_oh;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh = t_req[i] ? 2'b10 : 2'b01;
      bus.req_valid = exp_oh;
      if (t_req[i]) begin
        bus.req_opA[63:32] = t_a[i]; bus.req_opB[63:32] = t_b[i]; bus.req_op[11:6] = t_op[i];
      end else begin
        bus.req_opA[31:0] = t_a[i]; bus.req_opB[31:0] = t_b[i]; bus.req_op[5:0] = t_op[i];
      end
      #1;
      n_checks++; if (bus.req_ready !== exp_oh) begin n_fail++; $display("FAIL ops_grant%0d: got %b want %b", i, bus.req_ready, exp_oh); end
      step();
      bus.req_valid = 2'b00;
      step();
      n_checks++;
      if (bus.rsp_valid !== exp_oh || bus.rsp_result !== t_res[i] || bus.rsp_zf !== (t_res[i] == 32'd0)) begin
        n_fail++; $display("FAIL ops_result%0d: got %b %h/%b want %b %h/%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_zf, exp_oh, t_res[i], t_res[i] == 32'd0);
      end
      step();
    end
  endtask

`ifdef ALU_OP_CHECK_EN
  task automatic test_op_check();
    bus.req_valid     = 2'b01;
    bus.req_opA[31:0] = 32'd5;
    bus.req_opB[31:0] = 32'd6;
    bus.req_op[5:0]   = 6'h3F;
    bus.rsp_ready     = 2'b00;
    #1;
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL chk_grant: got %b want 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zf !== 1'b0) begin
      n_fail++; $display("FAIL chk_illegal: got %b err %b %h/%b want 01 1 0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_zf);
    end
    bus.rsp_ready = 2'b01;
    step();
    bus.req_valid     = 2'b01;
    bus.req_opA[31:0] = 32'd1;
    bus.req_opB[31:0] = 32'd1;
    bus.req_op[5:0]   = 6'h20;
    step();
    bus.req_valid = 2'b00;
    step();
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 32'd2) begin
      n_fail++; $display("FAIL chk_legal: got %b err %b %h want 01 0 2", bus.rsp_valid, bus.rsp_err, bus.rsp_result);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_ops();
`ifdef ALU_OP_CHECK_EN
    test_op_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
